// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared envelope state encoding and full-scale level
package synth_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    localparam logic [15:0] LEVEL_MAX = 16'h7FFF;

endpackage

// File: rtl/env_sat_step.sv
// rtl/env_sat_step.sv - saturating level add/subtract clamped to a bound
module env_sat_step (
    input  logic [14:0] i_level,
    input  logic [15:0] i_step,
    input  logic [14:0] i_bound,
    input  logic        i_dir,
    output logic [14:0] o_result
);

    logic [16:0] w_sum;
    logic [16:0] w_diff;

    assign w_sum  = {2'b00, i_level} + {1'b0, i_step};
    assign w_diff = {2'b00, i_level} - {1'b0, i_step};

    // i_dir=1 adds and caps at i_bound; i_dir=0 subtracts and floors at i_bound
    always_comb begin
        o_result = i_bound;
        if (i_dir) begin
            if (w_sum <= {2'b00, i_bound})
                o_result = w_sum[14:0];
        end else begin
            if (!w_diff[16] && (w_diff >= {2'b00, i_bound}))
                o_result = w_diff[14:0];
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// rtl/adsr_envelope.sv - per-voice ADSR envelope driving oscillator amplitude
// ADSR_EXP_RELEASE_EN selects exponential-like release instead of linear.
module adsr_envelope
    import synth_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_tick,
    input  logic        i_key_on,
    input  logic [14:0] i_attack_rate,
    input  logic [14:0] i_decay_rate,
    input  logic [14:0] i_sustain_level,
    input  logic [14:0] i_release_rate,
    output logic [15:0] o_amp,
    output logic        o_load_amp,
    output logic        o_busy,
    output logic [2:0]  o_state
);

    env_state_t  r_state;
    env_state_t  w_state_next;
    logic [14:0] r_level;
    logic [14:0] w_level_next;
    logic        r_key_prev;
    logic        r_load_amp;
    logic        w_rise;
    logic [15:0] w_step;
    logic [14:0] w_bound;
    logic        w_dir;
    logic [14:0] w_result;

    assign w_rise = i_key_on & ~r_key_prev;

    always_comb begin
        w_step  = '0;
        w_bound = '0;
        w_dir   = 1'b0;
        case (r_state)
            ATTACK: begin
                w_step  = {1'b0, i_attack_rate};
                w_bound = LEVEL_MAX[14:0];
                w_dir   = 1'b1;
            end
            DECAY: begin
                w_step  = {1'b0, i_decay_rate};
                w_bound = i_sustain_level;
            end
            RELEASE: begin
`ifdef ADSR_EXP_RELEASE_EN
                // the +1 guarantees the release reaches zero even at small levels
                w_step = {1'b0, r_level >> i_release_rate[3:0]} + 16'd1;
`else
                w_step = {1'b0, i_release_rate};
`endif
            end
            default: ;
        endcase
    end

`ifdef ADSR_EXP_RELEASE_EN
    logic w_unused_release_hi;
    assign w_unused_release_hi = ^i_release_rate[14:4];
`endif

    env_sat_step u_step (
        .i_level  (r_level),
        .i_step   (w_step),
        .i_bound  (w_bound),
        .i_dir    (w_dir),
        .o_result (w_result)
    );

    // gate rise outranks every stage-end condition
    always_comb begin
        w_state_next = r_state;
        w_level_next = r_level;
        if (w_rise) begin
            w_state_next = ATTACK;
        end else if (!i_key_on && (r_state == ATTACK || r_state == DECAY || r_state == SUSTAIN)) begin
            w_state_next = RELEASE;
        end else begin
            case (r_state)
                ATTACK: begin
                    w_level_next = w_result;
                    if (w_result == LEVEL_MAX[14:0])
                        w_state_next = DECAY;
                end
                DECAY: begin
                    w_level_next = w_result;
                    if (w_result == i_sustain_level)
                        w_state_next = SUSTAIN;
                end
                SUSTAIN: w_level_next = i_sustain_level;
                RELEASE: begin
                    w_level_next = w_result;
                    if (w_result == 15'd0)
                        w_state_next = IDLE;
                end
                default: w_level_next = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_level    <= '0;
            r_key_prev <= 1'b0;
            r_load_amp <= 1'b0;
        end else begin
            r_load_amp <= i_tick;
            if (i_tick) begin
                r_state    <= w_state_next;
                r_level    <= w_level_next;
                r_key_prev <= i_key_on;
            end
        end
    end

    assign o_amp      = {1'b0, r_level};
    assign o_load_amp = r_load_amp;
    assign o_busy     = (r_state != IDLE);
    assign o_state    = r_state;

endmodule

// File: tb/tb_adsr_envelope.sv
// tb/tb_adsr_envelope.sv - directed and random checks of adsr_envelope against a behavioural model
module tb_adsr_envelope;

    localparam int M_IDLE = 0, M_ATK = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        key_on;
    logic [14:0] attack_rate, decay_rate, sustain_level, release_rate;
    logic [15:0] amp;
    logic        load_amp, busy;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    int m_lvl, m_st;
    bit m_kp;
    int saved;

    always #5 clk = ~clk;

    adsr_envelope dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_tick          (tick),
        .i_key_on        (key_on),
        .i_attack_rate   (attack_rate),
        .i_decay_rate    (decay_rate),
        .i_sustain_level (sustain_level),
        .i_release_rate  (release_rate),
        .o_amp           (amp),
        .o_load_amp      (load_amp),
        .o_busy          (busy),
        .o_state         (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lvl = 0;
        m_st  = M_IDLE;
        m_kp  = 1'b0;
    endtask

    task automatic model_tick(input bit key);
        int step;
        if (key && !m_kp) begin
            m_st = M_ATK;
        end else if (!key && (m_st == M_ATK || m_st == M_DEC || m_st == M_SUS)) begin
            m_st = M_REL;
        end else begin
            case (m_st)
                M_ATK: begin
                    m_lvl = m_lvl + int'(attack_rate);
                    if (m_lvl >= 32767) begin m_lvl = 32767; m_st = M_DEC; end
                end
                M_DEC: begin
                    m_lvl = m_lvl - int'(decay_rate);
                    if (m_lvl <= int'(sustain_level)) begin m_lvl = int'(sustain_level); m_st = M_SUS; end
                end
                M_SUS: m_lvl = int'(sustain_level);
                M_REL: begin
`ifdef ADSR_EXP_RELEASE_EN
                    step = (m_lvl >> (int'(release_rate) % 16)) + 1;
`else
                    step = int'(release_rate);
`endif
                    m_lvl = m_lvl - step;
                    if (m_lvl <= 0) begin m_lvl = 0; m_st = M_IDLE; end
                end
                default: m_lvl = 0;
            endcase
        end
        m_kp = key;
    endtask

    task automatic do_tick(input bit key, input int gap);
        key_on = key;
        tick   = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        model_tick(key);
        chk("amp", amp, m_lvl);
        chk("state", state, m_st);
        chk("busy", busy, m_st != M_IDLE);
        chk("load_amp_pulse", load_amp, 1);
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            chk("load_amp_idle", load_amp, 0);
            chk("state_hold", state, m_st);
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; key_on = 1'b0;
        attack_rate = 15'h1000; decay_rate = 15'h0800; sustain_level = 15'h4000;
`ifdef ADSR_EXP_RELEASE_EN
        release_rate = 15'd4;
`else
        release_rate = 15'h1000;
`endif
        model_reset();
        #2;
        chk("rst_amp", amp, 0);
        chk("rst_state", state, M_IDLE);
        chk("rst_busy", busy, 0);
        chk("rst_load", load_amp, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 100; i++) do_tick(1'b0, 1);

        do_tick(1'b1, 1);
        for (int i = 0; i < 20 && m_st != M_DEC; i++) do_tick(1'b1, 1);
        chk("attack_sat", amp, 16'h7FFF);
        chk("attack_to_decay", state, M_DEC);
        for (int i = 0; i < 20 && m_st != M_SUS; i++) do_tick(1'b1, 0);
        chk("decay_clamp", amp, 16'h4000);
        chk("decay_to_sustain", state, M_SUS);
        sustain_level = 15'h3000;
        do_tick(1'b1, 0);
        chk("sustain_live", amp, 16'h3000);

        do_tick(1'b0, 0);
        chk("release_no_step", amp, 16'h3000);
        for (int i = 0; i < 400 && m_st != M_IDLE; i++) do_tick(1'b0, 0);
        chk("release_idle", state, M_IDLE);
        chk("release_zero", amp, 0);

        do_tick(1'b1, 0);
        for (int i = 0; i < 3; i++) do_tick(1'b1, 0);
        chk("attack_3000", amp, 16'h3000);
        do_tick(1'b0, 0);
        do_tick(1'b0, 0);
        saved = m_lvl;
        do_tick(1'b1, 0);
        chk("retrigger_state", state, M_ATK);
        chk("retrigger_legato", amp, saved);
        do_tick(1'b1, 0);
        chk("retrigger_step", amp, saved + 16'h1000);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 12) key_on = ~key_on;
            if ($urandom_range(0, 9) == 0) begin
                attack_rate   = ($urandom_range(0, 9) == 0) ? 15'd0 : 15'($urandom_range(1, 16'h3000));
                decay_rate    = ($urandom_range(0, 9) == 0) ? 15'd0 : 15'($urandom_range(1, 16'h3000));
                sustain_level = 15'($urandom_range(0, 16'h7FFF));
                release_rate  = 15'($urandom_range(1, 16'h2000));
            end
            do_tick(key_on, $urandom_range(0, 2));
        end

        key_on = 1'b0;
        for (int i = 0; i < 600 && m_st != M_IDLE; i++) do_tick(1'b0, 0);
        attack_rate = 15'h4000; decay_rate = 15'h0100; sustain_level = 15'h0000;
        do_tick(1'b1, 0);
        for (int i = 0; i < 5 && m_st != M_DEC; i++) do_tick(1'b1, 0);
        do_tick(1'b1, 0);
        chk("pre_reset_decay", state, M_DEC);
        rst = 1'b1;
        #1;
        chk("async_amp", amp, 0);
        chk("async_state", state, M_IDLE);
        chk("async_load", load_amp, 0);
        chk("async_busy", busy, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        do_tick(1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
